// File: rtl/uart_cmd_bridge_pkg.sv
// Shared types and constants for the UART command bridge and its neighbours.
// Holds the RX/TX state encodings and the standard one-byte response codes.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        HOLD    = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/uart_cmd_bridge_resp_tx_queue.sv
// resp_tx_queue: transmit side of the UART command bridge.
// Aligns the send_resp strobe with the cycle in which resp is valid, launches
// bytes on the UART transmitter and keeps one response pending behind the one
// in flight. Responses arriving while both slots are occupied are dropped and
// flagged on the sticky tx_ovr output.
module resp_tx_queue #(
    parameter int RESP_DLY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent,
    output logic       tx_ovr
);
    import uart_cmd_pkg::*;

    tx_state_t  state_q, state_d;
    logic       req_dly_q, req_dly_d;
    logic       req_cap;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] pend_data_q, pend_data_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       trmt_q, trmt_d;
    logic       resp_sent_q, resp_sent_d;
    logic       tx_ovr_q, tx_ovr_d;

    // Delay the request strobe so it lines up with the cycle resp is valid.
    always_comb begin
        req_dly_d = send_resp;
        req_cap   = (RESP_DLY == 0) ? send_resp : req_dly_q;
    end

    // Transmit FSM: launch, complete, and manage the single pending slot.
    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_data_d = pend_data_q;
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        resp_sent_d = 1'b0;
        tx_ovr_d    = tx_ovr_q;

        case (state_q)
            TX_IDLE: begin
                if (req_cap) begin
                    tx_data_d = resp;
                    trmt_d    = 1'b1;
                    state_d   = TX_BUSY;
                end
            end
            TX_BUSY: begin
                if (tx_done) begin
                    resp_sent_d = 1'b1;
                    if (pend_vld_q) begin
                        tx_data_d = pend_data_q;
                        trmt_d    = 1'b1;
                        if (req_cap) begin
                            pend_data_d = resp;
                        end else begin
                            pend_vld_d = 1'b0;
                        end
                    end else if (req_cap) begin
                        tx_data_d = resp;
                        trmt_d    = 1'b1;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else if (req_cap) begin
                    if (!pend_vld_q) begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = resp;
                    end else begin
                        tx_ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // Register the transmit state; synchronous reset abandons everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TX_IDLE;
            req_dly_q   <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_data_q <= 8'h00;
            tx_data_q   <= 8'h00;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            tx_ovr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_dly_q   <= req_dly_d;
            pend_vld_q  <= pend_vld_d;
            pend_data_q <= pend_data_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            resp_sent_q <= resp_sent_d;
            tx_ovr_q    <= tx_ovr_d;
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    assign resp_sent = resp_sent_q;
    assign tx_ovr    = tx_ovr_q;

endmodule

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: glue between the byte-level UART and the command block.
// RX side assembles {high, low} byte pairs into a 16-bit command and holds it
// until the consumer clears it; TX side lives in resp_tx_queue.
// Build option CMD_TIMEOUT_EN: when defined, a partial command is discarded
// (cmd_err pulse) if the low byte does not arrive within TIMEOUT cycles; when
// undefined, no counter exists and WAIT_LO waits indefinitely.
module uart_cmd_bridge #(
    parameter int TIMEOUT  = 1000000,
    parameter int TO_W     = $clog2(TIMEOUT + 1),
    parameter int RESP_DLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        cmd_err,
    output logic        tx_ovr
);
    import uart_cmd_pkg::*;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        clr_prev_q, clr_prev_d;
    logic        clr_rx_rdy_c;
    logic        rx_take;
`ifdef CMD_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            cmd_err_c;
`endif

    // RX FSM: consume bytes (never two cycles running), assemble and hold cmd.
    always_comb begin
        rx_state_d   = rx_state_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        clr_rx_rdy_c = 1'b0;
        rx_take      = rx_rdy && !clr_prev_q && !rst;
`ifdef CMD_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        cmd_err_c    = 1'b0;
`endif

        case (rx_state_q)
            WAIT_HI: begin
                if (rx_take) begin
                    cmd_d[15:8]  = rx_data;
                    clr_rx_rdy_c = 1'b1;
                    rx_state_d   = WAIT_LO;
`ifdef CMD_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            WAIT_LO: begin
                if (rx_take) begin
                    cmd_d[7:0]   = rx_data;
                    clr_rx_rdy_c = 1'b1;
                    cmd_rdy_d    = 1'b1;
                    rx_state_d   = HOLD;
                end else begin
`ifdef CMD_TIMEOUT_EN
                    if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        cmd_err_c  = !rst;
                        rx_state_d = WAIT_HI;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
`endif
                end
            end
            HOLD: begin
                if (clr_cmd_rdy) begin
                    cmd_rdy_d  = 1'b0;
                    rx_state_d = WAIT_HI;
                end
            end
            default: begin
                rx_state_d = WAIT_HI;
            end
        endcase

        clr_prev_d = clr_rx_rdy_c;
    end

    // Register the RX state, assembled command and consume history.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= WAIT_HI;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            clr_prev_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            clr_prev_q <= clr_prev_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Inter-byte timeout counter, only present when the timeout is built in.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign cmd_err = cmd_err_c;
`else
    assign cmd_err = 1'b0;
`endif

    assign clr_rx_rdy = clr_rx_rdy_c;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;

    resp_tx_queue #(
        .RESP_DLY (RESP_DLY)
    ) u_resp_tx_queue (
        .clk       (clk),
        .rst       (rst),
        .send_resp (send_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent),
        .tx_ovr    (tx_ovr)
    );

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Testbench for uart_cmd_bridge (TIMEOUT=16, RESP_DLY=1).
// Timeout scenarios adapt to whether CMD_TIMEOUT_EN is defined.
module tb_uart_cmd_bridge;
    import uart_cmd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        resp_sent;
    logic        cmd_err;
    logic        tx_ovr;

    int checks = 0;
    int passed = 0;

    uart_cmd_bridge #(
        .TIMEOUT  (16),
        .RESP_DLY (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .cmd_err     (cmd_err),
        .tx_ovr      (tx_ovr)
    );

    always #5 clk = ~clk;

    // Advance to the drive point of the next cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // UART receiver stand-in: hold a byte until the bridge consumes it.
    task automatic send_byte(input logic [7:0] b, input int max_wait, output int waited,
                             output bit got, output logic rdy_at, output logic err_at);
        waited = 0;
        got    = 1'b0;
        rdy_at = 1'b0;
        err_at = 1'b0;
        rx_rdy  = 1'b1;
        rx_data = b;
        while (!got && waited <= max_wait) begin
            @(negedge clk);
            if (clr_rx_rdy === 1'b1) begin
                got    = 1'b1;
                rdy_at = cmd_rdy;
                err_at = cmd_err;
            end
            next_cycle();
            if (!got) waited++;
        end
        rx_rdy = 1'b0;
    endtask

    // Consumer releases the held command.
    task automatic release_cmd();
        clr_cmd_rdy = 1'b1;
        next_cycle();
        clr_cmd_rdy = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_rdy = 1'b1; rx_data = 8'hFF; clr_cmd_rdy = 1'b0;
        send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++;
        if ({cmd, cmd_rdy, clr_rx_rdy, cmd_err} !== 19'd0)
            $display("[TB] FAIL reset_rx: got cmd=%h rdy=%b clr=%b err=%b, expected all 0", cmd, cmd_rdy, clr_rx_rdy, cmd_err);
        else passed++;
        checks++;
        if ({trmt, tx_data, resp_sent, tx_ovr} !== 11'd0)
            $display("[TB] FAIL reset_tx: got trmt=%b tx_data=%h sent=%b ovr=%b, expected all 0", trmt, tx_data, resp_sent, tx_ovr);
        else passed++;
        next_cycle();
        rst = 1'b0; rx_rdy = 1'b0;
        next_cycle();
    endtask

    task automatic test_cmd_assembly();
        int w0, w1, w2, bad;
        bit g0, g1, g2;
        logic r, e;
        logic [7:0] lo;
        send_byte(8'h41, 10, w0, g0, r, e);
        checks++;
        if (!g0 || w0 != 0) $display("[TB] FAIL hi_consume: got=%b wait=%0d, expected got=1 wait=0", g0, w0);
        else passed++;
        send_byte(8'h02, 10, w1, g1, r, e);
        checks++;
        if (!g1 || w1 != 1) $display("[TB] FAIL lo_spacing: got=%b wait=%0d, expected got=1 wait=1", g1, w1);
        else passed++;
        checks++;
        if (r !== 1'b0) $display("[TB] FAIL rdy_during_clr: got %b, expected 0", r);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h4102)
            $display("[TB] FAIL cmd_4102: got rdy=%b cmd=%h, expected rdy=1 cmd=4102", cmd_rdy, cmd);
        else passed++;
        next_cycle();
        rx_rdy = 1'b1; rx_data = 8'h80;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_rdy !== 1'b1 || cmd !== 16'h4102 || clr_rx_rdy !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL hold_backpressure: %0d bad cycles, expected 0", bad);
        else passed++;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (clr_rx_rdy !== 1'b0) $display("[TB] FAIL clr_cycle_no_consume: got %b, expected 0", clr_rx_rdy);
        else passed++;
        next_cycle();
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b1)
            $display("[TB] FAIL bp_consume: got rdy=%b clr=%b, expected rdy=0 clr=1", cmd_rdy, clr_rx_rdy);
        else passed++;
        next_cycle();
        rx_rdy = 1'b0;
        lo = 8'($urandom);
        send_byte(lo, 10, w2, g2, r, e);
        @(negedge clk);
        checks++;
        if (!g2 || cmd_rdy !== 1'b1 || cmd !== {8'h80, lo})
            $display("[TB] FAIL cmd_after_bp: got rdy=%b cmd=%h, expected rdy=1 cmd=%h", cmd_rdy, cmd, {8'h80, lo});
        else passed++;
        next_cycle();
        release_cmd();
    endtask

    task automatic test_random_cmds();
        int w, gap, dly;
        bit g1, g2;
        logic r, e;
        logic [7:0] hi, lo;
        for (int n = 0; n < 8; n++) begin
            hi  = 8'($urandom);
            lo  = 8'($urandom);
            gap = $urandom_range(0, 6);
            send_byte(hi, 10, w, g1, r, e);
            for (int i = 0; i < gap; i++) begin
                clr_cmd_rdy = 1'($urandom_range(0, 1));
                next_cycle();
            end
            clr_cmd_rdy = 1'b0;
            send_byte(lo, 10, w, g2, r, e);
            @(negedge clk);
            checks++;
            if (!g1 || !g2 || cmd_rdy !== 1'b1 || cmd !== {hi, lo})
                $display("[TB] FAIL rand_cmd%0d: got rdy=%b cmd=%h, expected rdy=1 cmd=%h", n, cmd_rdy, cmd, {hi, lo});
            else passed++;
            next_cycle();
            dly = $urandom_range(0, 3);
            repeat (dly) next_cycle();
            clr_cmd_rdy = 1'b1;
            next_cycle();
            clr_cmd_rdy = 1'b0;
            @(negedge clk);
            checks++;
            if (cmd_rdy !== 1'b0) $display("[TB] FAIL rand_release%0d: got %b, expected 0", n, cmd_rdy);
            else passed++;
            next_cycle();
        end
    endtask

    task automatic test_timeout();
        int w, n, bad;
        bit g, g2, found;
        logic r, e;
`ifdef CMD_TIMEOUT_EN
        send_byte(8'h12, 10, w, g, r, e);
        n = 0; found = 1'b0;
        while (!found && n < 40) begin
            n++;
            @(negedge clk);
            if (cmd_err === 1'b1) found = 1'b1;
            next_cycle();
        end
        checks++;
        if (!found || n != 16) $display("[TB] FAIL timeout_cycle: found=%b at %0d, expected cycle 16", found, n);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_err !== 1'b0 || cmd_rdy !== 1'b0)
            $display("[TB] FAIL timeout_pulse: got err=%b rdy=%b, expected 0 0", cmd_err, cmd_rdy);
        else passed++;
        next_cycle();
        send_byte(8'h00, 10, w, g, r, e);
        send_byte(8'h05, 10, w, g2, r, e);
        @(negedge clk);
        checks++;
        if (!g || !g2 || cmd_rdy !== 1'b1 || cmd !== 16'h0005)
            $display("[TB] FAIL after_timeout: got rdy=%b cmd=%h, expected rdy=1 cmd=0005", cmd_rdy, cmd);
        else passed++;
        next_cycle();
        release_cmd();
        send_byte(8'h3C, 10, w, g, r, e);
        repeat (15) next_cycle();
        send_byte(8'hC3, 0, w, g2, r, e);
        checks++;
        if (!g2 || e !== 1'b0) $display("[TB] FAIL byte_wins: got=%b err=%b, expected got=1 err=0", g2, e);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_rdy !== 1'b1 || cmd !== 16'h3CC3 || cmd_err !== 1'b0)
            $display("[TB] FAIL byte_wins_cmd: got rdy=%b cmd=%h err=%b, expected 1 3cc3 0", cmd_rdy, cmd, cmd_err);
        else passed++;
        next_cycle();
        release_cmd();
`else
        send_byte(8'h12, 10, w, g, r, e);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cmd_err !== 1'b0 || cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL no_timeout_wait: %0d bad cycles, expected 0", bad);
        else passed++;
        send_byte(8'h05, 10, w, g2, r, e);
        @(negedge clk);
        checks++;
        if (!g || !g2 || cmd_rdy !== 1'b1 || cmd !== 16'h1205)
            $display("[TB] FAIL no_timeout_cmd: got rdy=%b cmd=%h, expected rdy=1 cmd=1205", cmd_rdy, cmd);
        else passed++;
        next_cycle();
        release_cmd();
        n = 0; found = 1'b0;
`endif
    endtask

    task automatic test_reset_midstream();
        int w, bad;
        bit g, g1, g2;
        logic r, e;
        logic [7:0] a, b;
        send_resp = 1'b1; resp = 8'h00;
        next_cycle();
        send_resp = 1'b0; resp = 8'h77;
        next_cycle();
        send_byte(8'($urandom), 10, w, g, r, e);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        tx_done = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd !== 16'h0000 || cmd_rdy !== 1'b0 || trmt !== 1'b0)
            $display("[TB] FAIL mid_reset: got cmd=%h rdy=%b trmt=%b, expected 0000 0 0", cmd, cmd_rdy, trmt);
        else passed++;
        next_cycle();
        tx_done = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_sent !== 1'b0 || trmt !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL no_sent_after_reset: %0d bad cycles, expected 0", bad);
        else passed++;
        a = 8'($urandom);
        b = 8'($urandom);
        send_byte(a, 10, w, g1, r, e);
        send_byte(b, 10, w, g2, r, e);
        @(negedge clk);
        checks++;
        if (!g1 || !g2 || cmd_rdy !== 1'b1 || cmd !== {a, b})
            $display("[TB] FAIL cmd_after_reset: got rdy=%b cmd=%h, expected rdy=1 cmd=%h", cmd_rdy, cmd, {a, b});
        else passed++;
        next_cycle();
        release_cmd();
    endtask

    task automatic test_single_resp();
        int bad;
        send_resp = 1'b1; resp = 8'h5A;
        @(negedge clk);
        checks++;
        if (trmt !== 1'b0) $display("[TB] FAIL trmt_early0: got %b, expected 0", trmt);
        else passed++;
        next_cycle();
        send_resp = 1'b0; resp = ACK;
        @(negedge clk);
        checks++;
        if (trmt !== 1'b0) $display("[TB] FAIL trmt_early1: got %b, expected 0", trmt);
        else passed++;
        next_cycle();
        resp = 8'h00;
        @(negedge clk);
        checks++;
        if (trmt !== 1'b1 || tx_data !== ACK)
            $display("[TB] FAIL single_trmt: got trmt=%b tx_data=%h, expected 1 a5", trmt, tx_data);
        else passed++;
        next_cycle();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (trmt !== 1'b0 || tx_data !== ACK || resp_sent !== 1'b0) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL single_busy_stable: %0d bad cycles, expected 0", bad);
        else passed++;
        tx_done = 1'b1;
        next_cycle();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_sent !== 1'b1 || trmt !== 1'b0)
            $display("[TB] FAIL single_sent: got sent=%b trmt=%b, expected 1 0", resp_sent, trmt);
        else passed++;
        next_cycle();
        @(negedge clk);
        checks++;
        if (resp_sent !== 1'b0) $display("[TB] FAIL sent_pulse: got %b, expected 0", resp_sent);
        else passed++;
        next_cycle();
        tx_done = 1'b1;
        next_cycle();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_sent !== 1'b0 || trmt !== 1'b0)
            $display("[TB] FAIL idle_tx_done: got sent=%b trmt=%b, expected 0 0", resp_sent, trmt);
        else passed++;
        next_cycle();
    endtask

    task automatic test_queue_overrun();
        logic       sr [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] rv [6] = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        int tcount, bad;
        logic [7:0] tdata;
        tcount = 0; tdata = 8'h00;
        for (int i = 0; i < 6; i++) begin
            send_resp = sr[i]; resp = rv[i];
            @(negedge clk);
            if (trmt === 1'b1) begin
                tcount++;
                tdata = tx_data;
            end
            next_cycle();
        end
        send_resp = 1'b0;
        checks++;
        if (tcount != 1 || tdata !== 8'h11)
            $display("[TB] FAIL first_launch: got %0d launches data=%h, expected 1 11", tcount, tdata);
        else passed++;
        checks++;
        if (tx_ovr !== 1'b1) $display("[TB] FAIL ovr_set: got %b, expected 1", tx_ovr);
        else passed++;
        tx_done = 1'b1;
        next_cycle();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_sent !== 1'b1 || trmt !== 1'b1 || tx_data !== 8'h22)
            $display("[TB] FAIL chain_launch: got sent=%b trmt=%b data=%h, expected 1 1 22", resp_sent, trmt, tx_data);
        else passed++;
        next_cycle();
        repeat (2) next_cycle();
        tx_done = 1'b1;
        next_cycle();
        tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_sent !== 1'b1 || trmt !== 1'b0)
            $display("[TB] FAIL last_sent: got sent=%b trmt=%b, expected 1 0", resp_sent, trmt);
        else passed++;
        next_cycle();
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (trmt !== 1'b0 || tx_ovr !== 1'b1) bad++;
            next_cycle();
        end
        checks++;
        if (bad != 0) $display("[TB] FAIL dropped_stays_dropped: %0d bad cycles, expected 0", bad);
        else passed++;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ovr !== 1'b0) $display("[TB] FAIL ovr_cleared: got %b, expected 0", tx_ovr);
        else passed++;
        next_cycle();
    endtask

    // Random traffic against a model of a two-slot (in flight + pending) queue.
    task automatic test_back_to_back();
        logic [7:0] accq[$];
        int outstanding, launches, sents, bad_sent, bad_ovr, bad_order, bad_stable, bad_busy, cnt;
        bit busy, movr, sr_prev, done_prev, cap_now;
        logic [7:0] resp_val, cur_data;
        outstanding = 0; launches = 0; sents = 0; cnt = 0;
        bad_sent = 0; bad_ovr = 0; bad_order = 0; bad_stable = 0; bad_busy = 0;
        busy = 1'b0; movr = 1'b0; sr_prev = 1'b0; done_prev = 1'b0; cur_data = 8'h00;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy && cnt > 0) cnt--;
            tx_done  = busy && cnt == 0;
            cap_now  = sr_prev;
            resp_val = 8'($urandom);
            resp     = resp_val;
            send_resp = (cyc < 320) ? ($urandom_range(0, 9) < 4) : 1'b0;
            @(negedge clk);
            if (resp_sent !== done_prev) bad_sent++;
            if (resp_sent === 1'b1) sents++;
            if (tx_ovr !== movr) bad_ovr++;
            if (trmt === 1'b1) begin
                launches++;
                if (busy) bad_busy++;
                if (accq.size() == 0) bad_order++;
                else begin
                    if (tx_data !== accq[0]) bad_order++;
                    void'(accq.pop_front());
                end
                cur_data = tx_data;
            end else if (busy && tx_data !== cur_data) begin
                bad_stable++;
            end
            if (tx_done) begin
                busy = 1'b0;
                outstanding--;
            end
            if (trmt === 1'b1) begin
                busy = 1'b1;
                cnt  = $urandom_range(1, 5);
            end
            if (cap_now) begin
                if (outstanding < 2) begin
                    outstanding++;
                    accq.push_back(resp_val);
                end else begin
                    movr = 1'b1;
                end
            end
            done_prev = tx_done;
            sr_prev   = send_resp;
            next_cycle();
        end
        tx_done = 1'b0;
        send_resp = 1'b0;
        checks++;
        if (bad_sent != 0) $display("[TB] FAIL rand_resp_sent: %0d bad cycles, expected 0", bad_sent);
        else passed++;
        checks++;
        if (bad_order != 0 || bad_busy != 0)
            $display("[TB] FAIL rand_launch: order errs=%0d busy errs=%0d, expected 0 0", bad_order, bad_busy);
        else passed++;
        checks++;
        if (bad_stable != 0) $display("[TB] FAIL rand_tx_stable: %0d bad cycles, expected 0", bad_stable);
        else passed++;
        checks++;
        if (bad_ovr != 0) $display("[TB] FAIL rand_tx_ovr: %0d bad cycles, expected 0", bad_ovr);
        else passed++;
        checks++;
        if (accq.size() != 0 || outstanding != 0 || sents != launches)
            $display("[TB] FAIL rand_drain: left=%0d outstanding=%0d sent=%0d launched=%0d, expected 0 0 equal",
                     accq.size(), outstanding, sents, launches);
        else passed++;
    endtask

    // Bound the whole run so a stuck design still produces a verdict.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_cmd_assembly();
        test_random_cmds();
        test_timeout();
        test_reset_midstream();
        test_single_resp();
        test_queue_overrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
